uart_rx: RTL and testbench

UART receiver for the UART IP; sits directly downstream of `uart_baudgen` and consumes its 16x-oversampling `tick`. It synchronises the serial `rx` line, detects and qualifies the start bit, and samples each bit at its centre. It emits one byte per frame with a one-cycle valid strobe and framing/parity status.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver. It synchronises rx, qualifies the
// start bit at its centre, samples each data/parity/stop bit at its centre
// and reports one byte per frame together with framing and parity status.
//
// Output handshake: data_valid is a one-cycle strobe with no ready/backpressure.
// data, frame_err and parity_err are valid in the strobe cycle and then hold
// their values until the next frame completes. Errored frames also strobe,
// so a consumer must qualify data with the two flags.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);
    localparam logic          PAR_BIT  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   armed_q, armed_d;
    logic                   done;
    logic                   rx_m, rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic: every decision is taken only on a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        armed_d = armed_q;
        done    = 1'b0;
        // Line seen high re-arms start detection after a break.
        if (tick && rx_s) armed_d = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tick && !rx_s && armed_q) state_d = START;
            end
            START: begin
                if (tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        bit_d = '0;
                        // Still low at mid start bit: genuine start, else a glitch.
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) state_d = PAR_BIT ? PARITY : STOP;
                        else                   bit_d   = bit_q + BW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is caught.
                        cnt_d   = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                        if (!rx_s) armed_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame result registers: loaded and strobed one clk after the stop sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            data_valid <= done;
            if (done) begin
                data       <= shift_q;
                frame_err  <= ~rx_s;
                parity_err <= PAR_BIT & ((^shift_q) ^ par_q ^ ODD_BIT);
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Instance a is 8N1, instance b is
// 8E1. Frames are driven bit by bit; a monitor records each data_valid
// strobe and each test compares what it recorded against hand-derived values.
module tb_uart_rx;

    localparam int TICK_DIV = 4;                 // clk per tick
    localparam int BIT_CLK  = 16 * TICK_DIV;     // clk per bit

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b, ferr_a, ferr_b, perr_a, perr_b, busy_a, busy_b;
    logic [2:0] st_a, st_b;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int tdiv   = 0;

    // Scoreboard: expected {parity_err, frame_err, data} per frame.
    logic [9:0] exp_q[$];
    logic [9:0] obs_a[$];
    logic [9:0] obs_b[$];
    int         vcyc_a[$];
    int         busy_rise_a = 0;
    int         busy_fall_a = 0;
    logic       busy_prev_a = 1'b0;

    uart_rx u_a (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_a),
        .data(data_a), .data_valid(dv_a), .frame_err(ferr_a),
        .parity_err(perr_a), .busy(busy_a), .dbg_state(st_a)
    );

    uart_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_b),
        .data(data_b), .data_valid(dv_b), .frame_err(ferr_b),
        .parity_err(perr_b), .busy(busy_b), .dbg_state(st_b)
    );

    // Clock and tick generation.
    initial begin
        clk  = 1'b0;
        tick = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
        tick = (tdiv == 0);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dv_a) begin
            obs_a.push_back({perr_a, ferr_a, data_a});
            vcyc_a.push_back(cyc);
        end
        if (dv_b) obs_b.push_back({perr_b, ferr_b, data_b});
        if (busy_a && !busy_prev_a) busy_rise_a = cyc;
        if (!busy_a && busy_prev_a) busy_fall_a = cyc;
        busy_prev_a = busy_a;
    end

    // Driver tasks.
    task automatic drive_bit(input int sel, input logic v);
        @(negedge clk);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int sel, input int n);
        for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    task automatic take_frame(input int sel, output logic [9:0] got, output bit ok);
        got = 'x;
        ok  = 1'b0;
        if (sel == 0 && obs_a.size() > 0) begin got = obs_a.pop_front(); ok = 1'b1; end
        if (sel == 1 && obs_b.size() > 0) begin got = obs_b.pop_front(); ok = 1'b1; end
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (data_a !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data_a); end
        checks++; if (dv_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dv_a); end
        checks++; if ({ferr_a, perr_a} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {ferr_a, perr_a}); end
        checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (st_a !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", st_a); end
        rst = 1'b1;
        idle_bits(0, 20);
        checks++; if (obs_a.size() != 0) begin fails++; $display("FAIL reset_idle_valids: got %0d expected 0", obs_a.size()); end
        checks++; if ({data_a, ferr_a, perr_a, busy_a} !== 11'd0) begin fails++; $display("FAIL reset_idle_outputs: got %h expected 000", {data_a, ferr_a, perr_a, busy_a}); end
    endtask

    task automatic test_frame_a5;
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b00, 8'hA5});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        checks++; if (obs_a.size() != 1) begin fails++; $display("FAIL a5_count: got %0d expected 1", obs_a.size()); end
        checks++; if (vcyc_a.size() < 1 || busy_fall_a != vcyc_a[vcyc_a.size()-1]) begin fails++; $display("FAIL a5_busy_fall: got %0d expected valid cycle", busy_fall_a); end
        checks++; if (busy_fall_a - busy_rise_a != 152 * TICK_DIV) begin fails++; $display("FAIL a5_busy_len: got %0d expected %0d", busy_fall_a - busy_rise_a, 152 * TICK_DIV); end
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL a5_frame: got %h expected %h", got, exp); end
        vcyc_a.delete();
    endtask

    task automatic test_glitch;
        logic [9:0] got, exp;
        bit ok;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b expected 1", busy_a); end
        repeat (BIT_CLK) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL glitch_busy_low: got %b expected 0", busy_a); end
        checks++; if (obs_a.size() != 0) begin fails++; $display("FAIL glitch_valids: got %0d expected 0", obs_a.size()); end
        checks++; if ({ferr_a, perr_a, data_a} !== 10'h0A5) begin fails++; $display("FAIL glitch_hold: got %h expected 0a5", {ferr_a, perr_a, data_a}); end
        exp_q.push_back({2'b00, 8'h3C});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL glitch_next_frame: got %h expected %h", got, exp); end
        vcyc_a.delete();
    endtask

    task automatic test_frame_err;
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b01, 8'h3C});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle_bits(0, 2);
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL ferr_frame: got %h expected %h", got, exp); end
        checks++; if (ferr_a !== 1'b1) begin fails++; $display("FAIL ferr_hold: got %b expected 1", ferr_a); end
        exp_q.push_back({2'b00, 8'h81});
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL ferr_clear_frame: got %h expected %h", got, exp); end
        checks++; if (ferr_a !== 1'b0) begin fails++; $display("FAIL ferr_clear: got %b expected 0", ferr_a); end
        vcyc_a.delete();
    endtask

    task automatic test_back_to_back;
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b00, 8'h00});
        exp_q.push_back({2'b00, 8'hFF});
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        checks++; if (obs_a.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", obs_a.size()); end
        checks++; if (vcyc_a.size() != 2 || vcyc_a[1] - vcyc_a[0] != 10 * BIT_CLK) begin fails++; $display("FAIL b2b_spacing: got %0d entries expected spacing %0d", vcyc_a.size(), 10 * BIT_CLK); end
        for (int i = 0; i < 2; i++) begin
            take_frame(0, got, ok);
            exp = exp_q.pop_front();
            checks++; if (!ok || got !== exp) begin fails++; $display("FAIL b2b_frame%0d: got %h expected %h", i, got, exp); end
        end
        vcyc_a.delete();
    endtask

    task automatic test_break;
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b01, 8'h00});
        for (int i = 0; i < 30; i++) drive_bit(0, 1'b0);
        checks++; if (obs_a.size() != 1) begin fails++; $display("FAIL break_count: got %0d expected 1", obs_a.size()); end
        checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL break_busy: got %b expected 0", busy_a); end
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL break_frame: got %h expected %h", got, exp); end
        idle_bits(0, 2);
        exp_q.push_back({2'b00, 8'h42});
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL break_recover: got %h expected %h", got, exp); end
        vcyc_a.delete();
    endtask

    task automatic test_parity;
        logic [9:0] got, exp;
        bit ok;
        exp_q.push_back({2'b10, 8'h07});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle_bits(1, 1);
        take_frame(1, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL parity_bad: got %h expected %h", got, exp); end
        exp_q.push_back({2'b00, 8'h07});
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle_bits(1, 1);
        take_frame(1, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL parity_good: got %h expected %h", got, exp); end
        checks++; if (perr_b !== 1'b0) begin fails++; $display("FAIL parity_hold: got %b expected 0", perr_b); end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] got, exp;
        bit ok;
        logic [7:0] partial;
        partial = 8'hC3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, partial[i]);
        @(negedge clk);
        rst  = 1'b0;
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({data_a, ferr_a, perr_a, busy_a, dv_a} !== 12'd0) begin fails++; $display("FAIL midrst_outputs: got %h expected 000", {data_a, ferr_a, perr_a, busy_a, dv_a}); end
        checks++; if (st_a !== 3'd0) begin fails++; $display("FAIL midrst_state: got %0d expected 0", st_a); end
        repeat (8) @(negedge clk);
        rst = 1'b1;
        idle_bits(0, 12);
        checks++; if (obs_a.size() != 0) begin fails++; $display("FAIL midrst_valids: got %0d expected 0", obs_a.size()); end
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        take_frame(0, got, ok);
        exp = exp_q.pop_front();
        checks++; if (!ok || got !== exp) begin fails++; $display("FAIL midrst_next_frame: got %h expected %h", got, exp); end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_break();
        test_parity();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
